// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for the five-stage integer pipeline. Produces
// the load enables and bubble (flush) controls for the PC register and the
// IF/ID, ID/EX and EX/MEM pipeline registers.
//
// Conditions handled, highest priority first:
//   1. data-memory wait (mem_busy)  -> full freeze
//   2. mul/div occupancy            -> hold front end, let EX/MEM take bubbles
//   3. taken branch in EX           -> squash IF/ID and ID/EX (two bubbles)
//   4. load-use dependency          -> one-cycle stall with ID/EX bubble
//
// A two-state FSM (RUN / MD_WAIT) tracks the mul/div unit. A watchdog counts
// non-frozen MD_WAIT cycles; when it reaches MD_MAX_CYCLES the pipeline is
// released and md_timeout latches until reset.
//
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to build the stall-cycle
// and branch-flush performance counters. Without it both ports read zero and
// no counter flops exist.
//
// Parameters:
//   MD_MAX_CYCLES   watchdog limit on cycles spent waiting for md_done (>= 2)
//
// Ports:
//   clk                          pipeline clock, rising edge
//   rst                          asynchronous reset, active-low
//   id_rs1_addr, id_rs2_addr     source registers of the ID instruction
//   id_rs1_used, id_rs2_used     ID instruction really reads rs1 / rs2
//   ex_rd_addr                   destination register of the EX instruction
//   ex_mem_read                  EX instruction is a load
//   ex_branch_taken              EX resolved a taken branch/jump
//   ex_md_start                  EX issues a mul/div this cycle
//   md_done                      mul/div result valid this cycle
//   mem_busy                     data memory not ready, MEM must hold
//   pc_en, if_id_en, id_ex_en, ex_mem_en   register load enables
//   if_id_flush, id_ex_flush     load a bubble instead of data
//   md_busy                      FSM is in MD_WAIT
//   md_timeout                   sticky watchdog error
//   stall_cycles                 cycles with pc_en = 0 (perf build only)
//   flush_count                  taken-branch flush events (perf build only)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        md_done,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;

    logic load_use;
    logic md_issue_stall;
    logic wd_expire;
    logic md_release;
    logic md_hold;

    // A load whose destination feeds the ID instruction; x0 is never a hazard.
    assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    // A mul/div that finishes in its issue cycle needs no stall at all.
    assign md_issue_stall = (state == RUN) && ex_md_start && !md_done;

    // The watchdog expires in the cycle that would bring it to MD_MAX_CYCLES;
    // that cycle releases the pipeline exactly like md_done, so the held
    // mul/div leaves EX instead of re-triggering the stall from RUN.
    assign wd_expire  = (state == MD_WAIT) && (wd_cnt == WD_W'(MD_MAX_CYCLES - 1));
    assign md_release = (state == MD_WAIT) && (md_done || wd_expire);
    assign md_hold    = ((state == MD_WAIT) && !md_release) || md_issue_stall;

    assign md_busy = (state == MD_WAIT);

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst || mem_busy) begin
            // reset or memory wait: everything frozen
        end else if (md_hold) begin
            // EX stage gates its own write while the mul/div is busy
            ex_mem_en = 1'b1;
        end else if (md_release) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            wd_cnt     <= '0;
            md_timeout <= 1'b0;
        end else if (!mem_busy) begin
            case (state)
                RUN: begin
                    if (md_issue_stall) begin
                        state  <= MD_WAIT;
                        wd_cnt <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_release) begin
                        state <= RUN;
                        if (!md_done) begin
                            md_timeout <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic        branch_fire;

    assign branch_fire = rst && !mem_busy && !md_hold && !md_release && ex_branch_taken;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_q <= stall_q + 32'd1;
            end
            if (branch_fire) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  ex_rd_addr;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        ex_md_start;
    logic        md_done;
    logic        mem_busy;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
    logic        md_busy, md_timeout;
    logic [31:0] stall_cycles, flush_count;

    logic        w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_if_id_flush, w_id_ex_flush;
    logic        w_md_busy, w_md_timeout;
    logic [31:0] w_stall_cycles, w_flush_count;

    int passed = 0;
    int total  = 0;

    // Main instance with a limit longer than the mul/div sequence.
    pipe_hazard_ctrl #(.MD_MAX_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .md_done(md_done), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Short-watchdog instance, only observed in the watchdog sequence.
    pipe_hazard_ctrl #(.MD_MAX_CYCLES(4)) dut_wd (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .md_done(md_done), .mem_busy(mem_busy),
        .pc_en(w_pc_en), .if_id_en(w_if_id_en), .id_ex_en(w_id_ex_en), .ex_mem_en(w_ex_mem_en),
        .if_id_flush(w_if_id_flush), .id_ex_flush(w_id_ex_flush),
        .md_busy(w_md_busy), .md_timeout(w_md_timeout),
        .stall_cycles(w_stall_cycles), .flush_count(w_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, md_busy}
    localparam logic [6:0] E_RUN = 7'b1111_00_0;
    localparam logic [6:0] E_LU  = 7'b0011_01_0;
    localparam logic [6:0] E_BR  = 7'b1111_11_0;
    localparam logic [6:0] E_FRZ = 7'b0000_00_0;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ms;
        logic       md;
        logic       mb;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic mr, logic br, logic ms, logic md, logic mb,
                                logic [6:0] exp);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.mr = mr; v.br = br; v.ms = ms; v.md = md; v.mb = mb; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] main_out();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, md_busy};
    endfunction

    function automatic logic [6:0] wd_out();
        return {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_if_id_flush, w_id_ex_flush, w_md_busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic idle_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd_addr = 5'd0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_md_start = 1'b0;
        md_done = 1'b0; mem_busy = 1'b0;
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    int stall_n;
    int busy_n;

    initial begin
        rst = 1'b0;
        idle_inputs();

        vecs[0]  = mk("idle",        5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RUN);
        vecs[1]  = mk("lu_rs1",      5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, E_LU);
        vecs[2]  = mk("lu_rs2",      5'd3, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 0, E_LU);
        vecs[3]  = mk("rs1_unused",  5'd5, 5'd0, 0, 0, 5'd5, 1, 0, 0, 0, 0, E_RUN);
        vecs[4]  = mk("x0_load",     5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0, E_RUN);
        vecs[5]  = mk("not_load",    5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, 0, E_RUN);
        vecs[6]  = mk("br_over_lu",  5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, E_BR);
        vecs[7]  = mk("mem_frz_br",  5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1, E_FRZ);
        vecs[8]  = mk("md_same_cyc", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, E_RUN);
        vecs[9]  = mk("md_mem_frz",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, E_FRZ);
        vecs[10] = mk("rs1_differ",  5'd6, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, E_RUN);
        vecs[11] = mk("rs2_unused",  5'd1, 5'd9, 1, 0, 5'd9, 1, 0, 0, 0, 0, E_RUN);

        // Reset state while rst is held low.
        #3;
        chk("rst_outputs", 32'(main_out()), 32'(E_FRZ));
        chk("rst_timeout", 32'(md_timeout), 32'd0);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Combinational table, all in RUN state.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2;
            id_rs1_used = vecs[i].u1;  id_rs2_used = vecs[i].u2;
            ex_rd_addr = vecs[i].rd;   ex_mem_read = vecs[i].mr;
            ex_branch_taken = vecs[i].br; ex_md_start = vecs[i].ms;
            md_done = vecs[i].md;      mem_busy = vecs[i].mb;
            #1;
            chk(vecs[i].name, 32'(main_out()), 32'(vecs[i].exp));
        end

        // Load-use stall lasts one cycle; the bubble in EX clears the match.
        do_reset();
        @(negedge clk);
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1; ex_rd_addr = 5'd5; ex_mem_read = 1'b1;
        #1;
        chk("lu_cycle1", 32'(main_out()), 32'(E_LU));
        @(negedge clk);
        ex_rd_addr = 5'd0; ex_mem_read = 1'b0;
        #1;
        chk("lu_cycle2", 32'(main_out()), 32'(E_RUN));
        chk("lu_stall_cnt", stall_cycles, PERF ? 32'd1 : 32'd0);

        // Taken branch beats a load-use match; one flush event.
        do_reset();
        @(negedge clk);
        id_rs1_addr = 5'd5; id_rs1_used = 1'b1; ex_rd_addr = 5'd5; ex_mem_read = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(main_out()), 32'(E_BR));
        @(negedge clk);
        idle_inputs();
        #1;
        chk("br_after", 32'(main_out()), 32'(E_RUN));
        chk("br_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);
        chk("br_stall_cnt", stall_cycles, 32'd0);

        // Mul/div with md_done five cycles after issue.
        do_reset();
        stall_n = 0;
        busy_n  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ex_md_start = 1'b1;
            md_done = (k == 5);
            #1;
            if (!pc_en) stall_n++;
            if (md_busy) busy_n++;
            if (k == 2) chk("md_hold", 32'(main_out()), 32'(7'b0001_00_1));
            if (k == 5) chk("md_release", 32'(main_out()), 32'(7'b1111_00_1));
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("md_pc_stall_cycles", 32'(stall_n), 32'd5);
        chk("md_busy_cycles", 32'(busy_n), 32'd5);
        chk("md_after", 32'(main_out()), 32'(E_RUN));
        chk("md_stall_cnt", stall_cycles, PERF ? 32'd5 : 32'd0);
        chk("md_no_timeout", 32'(md_timeout), 32'd0);

        // Watchdog on the short-limit instance, with a mem_busy pulse inside.
        do_reset();
        @(negedge clk);
        ex_md_start = 1'b1;
        #1;
        chk("wd_c0", 32'(wd_out()), 32'(7'b0001_00_0));
        @(negedge clk);
        #1;
        chk("wd_c1", 32'(wd_out()), 32'(7'b0001_00_1));
        @(negedge clk);
        @(negedge clk);
        mem_busy = 1'b1;
        #1;
        chk("wd_frozen", 32'(wd_out()), 32'(7'b0000_00_1));
        @(negedge clk);
        mem_busy = 1'b0;
        #1;
        chk("wd_extended", 32'(wd_out()), 32'(7'b0001_00_1));
        chk("wd_extended_to", 32'(w_md_timeout), 32'd0);
        @(negedge clk);
        #1;
        chk("wd_release", 32'(wd_out()), 32'(7'b1111_00_1));
        @(negedge clk);
        ex_md_start = 1'b0;
        #1;
        chk("wd_timeout_set", 32'(w_md_timeout), 32'd1);
        chk("wd_back_run", 32'(wd_out()), 32'(E_RUN));
        @(negedge clk);
        ex_md_start = 1'b1;
        #1;
        chk("wd_timeout_sticky", 32'(w_md_timeout), 32'd1);
        chk("wd_new_md_stall", 32'(wd_out()), 32'(7'b0001_00_0));

        // Asynchronous reset in the middle of MD_WAIT.
        do_reset();
        @(negedge clk);
        ex_md_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("ar_in_wait", 32'(md_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_immediate", 32'(main_out()), 32'(E_FRZ));
        ex_md_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_after", 32'(main_out()), 32'(E_RUN));
        chk("ar_stall_cnt", stall_cycles, 32'd0);
        chk("ar_timeout", 32'(md_timeout), 32'd0);
        @(negedge clk);
        #1;
        chk("ar_state_run", 32'(main_out()), 32'(E_RUN));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
